// File: rtl/surf_axil_pkg.sv
// Shared types and constants for the SURF AXI4-Lite register initiator.
package surf_axil_pkg;

    localparam int unsigned AXIL_ADDR_WIDTH = 7;
    localparam int unsigned AXIL_DATA_WIDTH = 32;
    localparam int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_e;

    typedef struct packed {
        logic                       write;
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [AXIL_DATA_WIDTH-1:0] wdata;
        logic [AXIL_STRB_WIDTH-1:0] wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/surf_axil_master.sv
// AXI4-Lite initiator: turns one register command into a full AW/W/B or AR/R
// exchange with the SURF s00_axi slave and returns data/response on a valid/ready port.
module surf_axil_master
    import surf_axil_pkg::*;
#(
    parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH = 7,
    parameter int unsigned TIMEOUT_CYCLES       = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_timeout,
    output logic                                busy,
    output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_S00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int unsigned AW   = C_S00_AXI_ADDR_WIDTH;
    localparam int unsigned DW   = C_S00_AXI_DATA_WIDTH;
    localparam int unsigned SW   = C_S00_AXI_DATA_WIDTH / 8;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_e        state;
    axil_cmd_t     cmd_in;
    logic [TW-1:0] tcnt;
    logic          expired;

    assign m00_axi_awprot = PROT_DEFAULT;
    assign m00_axi_arprot = PROT_DEFAULT;

    always_comb begin
        cmd_in       = '0;
        cmd_in.write = cmd_write;
        cmd_in.addr  = AXIL_ADDR_WIDTH'(cmd_addr);
        cmd_in.wdata = AXIL_DATA_WIDTH'(cmd_wdata);
        cmd_in.wstrb = AXIL_STRB_WIDTH'(cmd_wstrb);
    end

    // Expiry only counts in the response-wait states; a handshake on the same cycle takes priority.
    assign expired = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TLIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cmd_ready       <= 1'b0;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= '0;
            rsp_timeout     <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wstrb   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            tcnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_in.write) begin
                            state           <= WR_AW_W;
                            m00_axi_awaddr  <= AW'(cmd_in.addr);
                            m00_axi_wdata   <= DW'(cmd_in.wdata);
                            m00_axi_wstrb   <= SW'(cmd_in.wstrb);
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                        end else begin
                            state           <= RD_AR;
                            m00_axi_araddr  <= AW'(cmd_in.addr);
                            m00_axi_arvalid <= 1'b1;
                        end
                    end
                end
                // AW and W retire independently; leave once neither is still pending.
                WR_AW_W: begin
                    if (m00_axi_awready) m00_axi_awvalid <= 1'b0;
                    if (m00_axi_wready)  m00_axi_wvalid  <= 1'b0;
                    if ((!m00_axi_awvalid || m00_axi_awready) &&
                        (!m00_axi_wvalid  || m00_axi_wready)) begin
                        state          <= WR_B;
                        m00_axi_bready <= 1'b1;
                        tcnt           <= '0;
                    end
                end
                WR_B: begin
                    if (m00_axi_bvalid) begin
                        state          <= RSP;
                        m00_axi_bready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_resp       <= m00_axi_bresp;
                        rsp_rdata      <= '0;
                        rsp_timeout    <= 1'b0;
                    end else if (expired) begin
                        state          <= RSP;
                        m00_axi_bready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_resp       <= RESP_SLVERR;
                        rsp_rdata      <= '0;
                        rsp_timeout    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_AR: begin
                    if (m00_axi_arready) begin
                        state           <= RD_R;
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        tcnt            <= '0;
                    end
                end
                RD_R: begin
                    if (m00_axi_rvalid) begin
                        state          <= RSP;
                        m00_axi_rready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_resp       <= m00_axi_rresp;
                        rsp_rdata      <= m00_axi_rdata;
                        rsp_timeout    <= 1'b0;
                    end else if (expired) begin
                        state          <= RSP;
                        m00_axi_rready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_resp       <= RESP_SLVERR;
                        rsp_rdata      <= '0;
                        rsp_timeout    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                // Response is held until consumed; the next command waits one more cycle.
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_surf_axil_master.sv
// Randomized bench for surf_axil_master: a timeline model derived from slave delays
// predicts every output on every cycle.
module tb_surf_axil_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;
    logic [6:0]  m00_axi_awaddr;
    logic [2:0]  m00_axi_awprot;
    logic        m00_axi_awvalid;
    logic        m00_axi_awready;
    logic [31:0] m00_axi_wdata;
    logic [3:0]  m00_axi_wstrb;
    logic        m00_axi_wvalid;
    logic        m00_axi_wready;
    logic [1:0]  m00_axi_bresp;
    logic        m00_axi_bvalid;
    logic        m00_axi_bready;
    logic [6:0]  m00_axi_araddr;
    logic [2:0]  m00_axi_arprot;
    logic        m00_axi_arvalid;
    logic        m00_axi_arready;
    logic [31:0] m00_axi_rdata;
    logic [1:0]  m00_axi_rresp;
    logic        m00_axi_rvalid;
    logic        m00_axi_rready;

    surf_axil_master #(
        .C_S00_AXI_DATA_WIDTH(32),
        .C_S00_AXI_ADDR_WIDTH(7),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awprot(m00_axi_awprot),
        .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m00_axi_awready),
        .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
        .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
        .m00_axi_bready(m00_axi_bready),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arprot(m00_axi_arprot),
        .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;

    // Cycle index k = interval after the k-th rising edge; rel_cyc = first cycle with cmd_ready.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rel_cyc <= cyc + 2;
    end

    // Current transaction timeline, all in absolute cycle numbers.
    bit          tx_valid = 1'b0;
    bit          tx_write;
    logic [6:0]  tx_addr;
    logic [31:0] tx_wdata;
    logic [3:0]  tx_wstrb;
    int          tN, tAWend, tWend, tARend, tB, tL, tS, tE;
    logic [31:0] ex_rdata;
    logic [1:0]  ex_resp;
    bit          ex_to;

    // Observations of the DUT used by directed literal checks.
    int          obs_acc, obs_rsp_c, obs_aw_n, obs_w_n, obs_rdy_n;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_resp;
    logic        obs_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        int c;
        bit bsy, awv, wv, arv, wt, rv;
        if (!rst) begin
            c   = cyc;
            bsy = tx_valid && (c >= tN + 1) && (c <= tE);
            awv = tx_valid && tx_write && (c >= tN + 1) && (c <= tAWend);
            wv  = tx_valid && tx_write && (c >= tN + 1) && (c <= tWend);
            arv = tx_valid && !tx_write && (c >= tN + 1) && (c <= tARend);
            wt  = tx_valid && (c >= tB) && (c <= tL);
            rv  = tx_valid && (c >= tS) && (c <= tE);
            chk("cmd_ready", 32'(cmd_ready), 32'((c >= rel_cyc) && !bsy));
            chk("busy", 32'(busy), 32'(bsy));
            chk("awvalid", 32'(m00_axi_awvalid), 32'(awv));
            chk("wvalid", 32'(m00_axi_wvalid), 32'(wv));
            chk("arvalid", 32'(m00_axi_arvalid), 32'(arv));
            chk("bready", 32'(m00_axi_bready), 32'(wt && tx_write));
            chk("rready", 32'(m00_axi_rready), 32'(wt && !tx_write));
            chk("rsp_valid", 32'(rsp_valid), 32'(rv));
            chk("prot", 32'({m00_axi_awprot, m00_axi_arprot}), 32'd0);
            if (awv) chk("awaddr", 32'(m00_axi_awaddr), 32'(tx_addr));
            if (wv) begin
                chk("wdata", m00_axi_wdata, tx_wdata);
                chk("wstrb", 32'(m00_axi_wstrb), 32'(tx_wstrb));
            end
            if (arv) chk("araddr", 32'(m00_axi_araddr), 32'(tx_addr));
            if (rv) begin
                chk("rsp_rdata", rsp_rdata, ex_rdata);
                chk("rsp_resp", 32'(rsp_resp), 32'(ex_resp));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(ex_to));
            end
            if (cmd_valid && cmd_ready) begin
                obs_acc = c; obs_rsp_c = -1; obs_aw_n = 0; obs_w_n = 0; obs_rdy_n = 0;
            end
            if (m00_axi_awvalid) obs_aw_n++;
            if (m00_axi_wvalid) obs_w_n++;
            if (m00_axi_bready || m00_axi_rready) obs_rdy_n++;
            if (rsp_valid && obs_rsp_c < 0) begin
                obs_rsp_c = c; obs_rdata = rsp_rdata; obs_resp = rsp_resp; obs_to = rsp_timeout;
            end
        end
    end

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, 32'({cmd_ready, busy, rsp_valid, rsp_timeout, rsp_resp, m00_axi_awvalid,
                                  m00_axi_wvalid, m00_axi_arvalid, m00_axi_bready, m00_axi_rready}), 32'd0);
        chk({name, "_addr"}, 32'({m00_axi_awaddr, m00_axi_araddr, m00_axi_awprot, m00_axi_arprot,
                                  m00_axi_wstrb}), 32'd0);
        chk({name, "_wdata"}, m00_axi_wdata, 32'd0);
        chk({name, "_rdata"}, rsp_rdata, 32'd0);
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; m00_axi_awready = 0; m00_axi_wready = 0; m00_axi_arready = 0;
        m00_axi_bvalid = 0; m00_axi_bresp = '0; m00_axi_rvalid = 0; m00_axi_rdata = '0; m00_axi_rresp = '0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            cmd_valid = 0;
            rsp_ready = 1'($urandom);
            m00_axi_awready = 1'($urandom); m00_axi_wready = 1'($urandom); m00_axi_arready = 1'($urandom);
            m00_axi_bvalid = 1'($urandom); m00_axi_rvalid = 1'($urandom);
            m00_axi_rdata = $urandom; m00_axi_bresp = 2'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Runs one command from the current (idle) cycle; dd = B/R delay after READY rises, >=TO never answers.
    task automatic run_tx(input bit wr, input logic [6:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int da, input int dw, input int dd, input logic [1:0] resp,
                          input logic [31:0] rd, input int dk, input int abort);
        int n;
        bit hs, win;
        n = cyc;
        hs = (dd <= TO - 1);
        tx_write = wr; tx_addr = addr; tx_wdata = wd; tx_wstrb = ws;
        tN = n;
        if (wr) begin
            tAWend = n + 1 + da; tWend = n + 1 + dw; tARend = -10;
            tB = n + 2 + ((da > dw) ? da : dw);
        end else begin
            tARend = n + 1 + da; tAWend = -10; tWend = -10;
            tB = n + 2 + da;
        end
        tL = hs ? tB + dd : tB + TO - 1;
        tS = tL + 1;
        tE = tS + dk;
        ex_resp  = hs ? resp : 2'b10;
        ex_to    = !hs;
        ex_rdata = (wr || !hs) ? 32'd0 : rd;
        tx_valid = 1'b1;
        for (int c = n; c <= tE; c++) begin
            if (c == n) begin
                cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
            end else begin
                cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 7'($urandom);
                cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end
            win = (c >= tB) && (c <= tL);
            m00_axi_awready = (wr && c == tAWend) || ((c < n + 1 || c > tAWend) && $urandom_range(0, 3) == 0);
            m00_axi_wready  = (wr && c == tWend) || ((c < n + 1 || c > tWend) && $urandom_range(0, 3) == 0);
            m00_axi_arready = (!wr && c == tARend) || ((c < n + 1 || c > tARend) && $urandom_range(0, 3) == 0);
            m00_axi_bvalid  = (wr && c == tB + dd) || (!(wr && win) && $urandom_range(0, 3) == 0);
            m00_axi_bresp   = (wr && c == tB + dd) ? resp : 2'($urandom);
            m00_axi_rvalid  = (!wr && c == tB + dd) || (!(!wr && win) && $urandom_range(0, 3) == 0);
            m00_axi_rdata   = (!wr && c == tB + dd) ? rd : $urandom;
            m00_axi_rresp   = (!wr && c == tB + dd) ? resp : 2'($urandom);
            rsp_ready       = (c == tE) || (c < tS && $urandom_range(0, 1) == 1);
            if (abort >= 0 && c == tB + abort) begin
                #1 rst = 1;
                #1 chk_zero("reset_mid");
                @(posedge clk); @(posedge clk); #1;
                rst = 0; tx_valid = 1'b0;
                idle_inputs();
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        int pe;
        rst = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_por");
        rst = 0;
        @(posedge clk); #1;

        // Zero-wait write.
        run_tx(1, 7'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, -1);
        chk("t1_accept", 32'(obs_acc), 32'(tN));
        chk("t1_latency", 32'(obs_rsp_c - obs_acc), 32'd3);
        chk("t1_resp", 32'(obs_resp), 32'd0);
        chk("t1_rdata", obs_rdata, 32'd0);
        chk("t1_bready_cycles", 32'(obs_rdy_n), 32'd1);

        // AWREADY at +1, WREADY at +4.
        run_tx(1, 7'h08, 32'h12345678, 4'h3, 0, 3, 2, 2'b01, 32'h0, 1, -1);
        chk("t2_aw_cycles", 32'(obs_aw_n), 32'd1);
        chk("t2_w_cycles", 32'(obs_w_n), 32'd4);
        chk("t2_latency", 32'(obs_rsp_c - obs_acc), 32'd8);
        chk("t2_resp", 32'(obs_resp), 32'd1);

        // Read with 3-cycle R stall.
        run_tx(0, 7'h10, 32'h0, 4'h0, 0, 0, 3, 2'b00, 32'h000000A5, 0, -1);
        chk("t3_rdata", obs_rdata, 32'h000000A5);
        chk("t3_resp", 32'(obs_resp), 32'd0);
        chk("t3_rready_cycles", 32'(obs_rdy_n), 32'd4);
        chk("t3_latency", 32'(obs_rsp_c - obs_acc), 32'd6);

        // B never arrives: timeout after 8 WR_B cycles.
        run_tx(1, 7'h20, 32'hCAFEF00D, 4'hC, 1, 0, 99, 2'b00, 32'h0, 2, -1);
        chk("t4_timeout", 32'(obs_to), 32'd1);
        chk("t4_resp", 32'(obs_resp), 32'd2);
        chk("t4_bready_cycles", 32'(obs_rdy_n), 32'd8);
        chk("t4_latency", 32'(obs_rsp_c - obs_acc), 32'd11);

        // B on the expiry cycle wins over timeout.
        run_tx(1, 7'h24, 32'h0BADC0DE, 4'hF, 0, 0, 7, 2'b01, 32'h0, 0, -1);
        chk("t4b_timeout", 32'(obs_to), 32'd0);
        chk("t4b_resp", 32'(obs_resp), 32'd1);
        chk("t4b_latency", 32'(obs_rsp_c - obs_acc), 32'd10);

        // Read timeout.
        run_tx(0, 7'h28, 32'h0, 4'h0, 2, 0, 99, 2'b00, 32'h55AA55AA, 0, -1);
        chk("t4c_timeout", 32'(obs_to), 32'd1);
        chk("t4c_rdata", obs_rdata, 32'd0);

        // Response held 5 cycles, next command follows immediately.
        run_tx(0, 7'h30, 32'h0, 4'h0, 0, 0, 0, 2'b11, 32'h87654321, 5, -1);
        pe = tE;
        run_tx(1, 7'h34, 32'hA5A5A5A5, 4'h5, 0, 0, 0, 2'b00, 32'h0, 0, -1);
        chk("t5_next_accept", 32'(obs_acc), 32'(pe + 1));

        // Reset mid RD_R, then normal traffic.
        run_tx(0, 7'h38, 32'h0, 4'h0, 0, 0, 99, 2'b00, 32'h0, 0, 2);
        run_tx(1, 7'h3C, 32'h11223344, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, -1);
        chk("t6_wr_latency", 32'(obs_rsp_c - obs_acc), 32'd3);
        run_tx(0, 7'h3C, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h11223344, 0, -1);
        chk("t6_rd_latency", 32'(obs_rsp_c - obs_acc), 32'd3);
        chk("t6_rdata", obs_rdata, 32'h11223344);

        for (int i = 0; i < 200; i++) begin
            int dd;
            idle(int'($urandom_range(0, 2)));
            dd = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 9));
            run_tx(1'($urandom), 7'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), dd, 2'($urandom),
                   $urandom, int'($urandom_range(0, 3)), -1);
            chk("rand_accept", 32'(obs_acc), 32'(tN));
        end

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
